// File: rtl/uart_mem_pkg.sv
// Shared command bytes, FSM state type and byte-sizing helper for uart_mem_bridge.
package uart_mem_pkg;

  localparam logic [7:0] CMD_WR   = 8'h57;
  localparam logic [7:0] CMD_RD   = 8'h52;
  localparam logic [7:0] ACK_BYTE = 8'h4B;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_CNT,
    ST_WDATA,
    ST_WSTROBE,
    ST_RISSUE,
    ST_RWAIT,
    ST_RSEND,
    ST_ACK
  } state_e;

  function automatic int unsigned ceil_bytes(input int unsigned bits);
    return (bits + 32'd7) / 32'd8;
  endfunction

endpackage

// File: rtl/uart_mem_word_serdes.sv
// Byte/word converter shared by both directions: shifts received bytes into a word,
// or walks a loaded word out MSB-first with a byte index.
module uart_mem_word_serdes
  import uart_mem_pkg::*;
#(
  parameter int unsigned DATA_W = 16
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_clr,
  input  logic              i_shift,
  input  logic              i_load,
  input  logic              i_next,
  input  logic [7:0]        i_byte,
  input  logic [DATA_W-1:0] i_word,
  output logic [DATA_W-1:0] o_word_nxt_c,
  output logic [7:0]        o_byte_nxt_c,
  output logic              o_last_c
);

  localparam int unsigned DB = ceil_bytes(DATA_W);
  localparam int unsigned EW = DB * 8;
  localparam int unsigned IW = (DB > 1) ? $clog2(DB) : 1;

  logic [DATA_W-1:0] r_word;
  logic [IW-1:0]     r_idx;
  logic [EW-1:0]     w_sel;
  logic [IW-1:0]     w_idx_nxt;

  // Excess high bits of the first byte fall off the top of the word
  assign o_word_nxt_c = DATA_W'({r_word, i_byte});
  assign o_last_c     = (r_idx == IW'(DB - 1));

  // Byte that becomes current after this cycle; partial top byte reads as zero
  always_comb begin
    w_sel        = i_load ? EW'(i_word) : EW'(r_word);
    w_idx_nxt    = i_load ? '0 : r_idx + IW'(1);
    o_byte_nxt_c = '0;
    for (int unsigned k = 0; k < DB; k++) begin
      if (w_idx_nxt == IW'(k)) o_byte_nxt_c = w_sel[(DB-1-k)*8 +: 8];
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_word <= '0;
      r_idx  <= '0;
    end else if (i_clr) begin
      r_idx <= '0;
    end else if (i_load) begin
      r_word <= i_word;
      r_idx  <= '0;
    end else if (i_shift) begin
      r_word <= o_word_nxt_c;
      r_idx  <= o_last_c ? '0 : r_idx + IW'(1);
    end else if (i_next) begin
      r_idx <= r_idx + IW'(1);
    end
  end

endmodule

// File: rtl/uart_mem_bridge.sv
// Framed burst read/write bridge from a UART byte stream to a synchronous RAM port.
// Optional inter-byte timeout abort is built when UART_MEM_TIMEOUT_EN is defined.
module uart_mem_bridge
  import uart_mem_pkg::*;
#(
  parameter int unsigned ADDR_W      = 10,
  parameter int unsigned DATA_W      = 16,
  parameter int unsigned RD_LAT      = 1,
  parameter int unsigned TIMEOUT_CYC = 500000
) (
  input  logic              sys_clk,
  input  logic              sys_rst_n,
  input  logic [7:0]        rx_data,
  input  logic              rx_valid,
  output logic [7:0]        tx_data,
  output logic              tx_valid,
  input  logic              tx_ready,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  output logic              mem_wren,
  output logic              mem_rden,
  input  logic [DATA_W-1:0] mem_rdata,
  output logic              busy,
  output logic              timeout
);

  localparam int unsigned AB       = ceil_bytes(ADDR_W);
  localparam int unsigned AIW      = (AB > 1) ? $clog2(AB) : 1;
  localparam logic [1:0]  LAT_LAST = 2'(RD_LAT - 1);

  state_e            r_state;
  logic              r_is_rd;
  logic [AIW-1:0]    r_abyte;
  logic [8:0]        r_words;
  logic [1:0]        r_lat;
  logic [7:0]        r_tx_data;
  logic              r_tx_valid;
  logic [ADDR_W-1:0] r_addr;
  logic [DATA_W-1:0] r_wdata;
  logic              r_wren;
  logic              r_rden;
  logic              r_busy;

  logic              w_shift;
  logic              w_load;
  logic              w_next;
  logic              w_clr;
  logic              w_last;
  logic [DATA_W-1:0] w_word_nxt;
  logic [7:0]        w_byte_nxt;

`ifdef UART_MEM_TIMEOUT_EN
  localparam int unsigned TW = $clog2(TIMEOUT_CYC + 1);
  logic [TW-1:0] r_tcnt;
  logic          r_timeout;
  assign timeout = r_timeout;
`else
  logic w_unused_timeout_cfg;
  assign w_unused_timeout_cfg = ^32'(TIMEOUT_CYC);
  assign timeout = 1'b0;
`endif

  assign w_clr   = (r_state == ST_IDLE);
  assign w_shift = (r_state == ST_WDATA) && rx_valid;
  assign w_load  = (r_state == ST_RWAIT) && (r_lat == LAT_LAST);
  assign w_next  = (r_state == ST_RSEND) && tx_ready && !w_last;

  uart_mem_word_serdes #(.DATA_W(DATA_W)) u_serdes (
    .clk          (sys_clk),
    .rst_n        (sys_rst_n),
    .i_clr        (w_clr),
    .i_shift      (w_shift),
    .i_load       (w_load),
    .i_next       (w_next),
    .i_byte       (rx_data),
    .i_word       (mem_rdata),
    .o_word_nxt_c (w_word_nxt),
    .o_byte_nxt_c (w_byte_nxt),
    .o_last_c     (w_last)
  );

  always_ff @(posedge sys_clk or negedge sys_rst_n) begin
    if (!sys_rst_n) begin
      r_state    <= ST_IDLE;
      r_is_rd    <= 1'b0;
      r_abyte    <= '0;
      r_words    <= '0;
      r_lat      <= '0;
      r_tx_data  <= '0;
      r_tx_valid <= 1'b0;
      r_addr     <= '0;
      r_wdata    <= '0;
      r_wren     <= 1'b0;
      r_rden     <= 1'b0;
      r_busy     <= 1'b0;
`ifdef UART_MEM_TIMEOUT_EN
      r_tcnt     <= '0;
      r_timeout  <= 1'b0;
`endif
    end else begin
      r_wren <= 1'b0;
      r_rden <= 1'b0;
      case (r_state)
        ST_IDLE: if (rx_valid && (rx_data == CMD_WR || rx_data == CMD_RD)) begin
          r_is_rd <= (rx_data == CMD_RD);
          r_abyte <= '0;
          r_busy  <= 1'b1;
          r_state <= ST_ADDR;
        end
        ST_ADDR: if (rx_valid) begin
          r_addr <= ADDR_W'({r_addr, rx_data});
          if (r_abyte == AIW'(AB - 1)) r_state <= ST_CNT;
          else                         r_abyte <= r_abyte + AIW'(1);
        end
        ST_CNT: if (rx_valid) begin
          r_words <= (rx_data == 8'd0) ? 9'd256 : {1'b0, rx_data};
          if (r_is_rd) begin
            r_rden  <= 1'b1;
            r_state <= ST_RISSUE;
          end else begin
            r_state <= ST_WDATA;
          end
        end
        ST_WDATA: if (rx_valid && w_last) begin
          r_wdata <= w_word_nxt;
          r_wren  <= 1'b1;
          r_state <= ST_WSTROBE;
        end
        ST_WSTROBE: begin
          r_addr  <= r_addr + ADDR_W'(1);
          r_words <= r_words - 9'd1;
          if (r_words == 9'd1) begin
            r_tx_data  <= ACK_BYTE;
            r_tx_valid <= 1'b1;
            r_state    <= ST_ACK;
          end else begin
            r_state <= ST_WDATA;
          end
        end
        ST_RISSUE: begin
          r_lat   <= '0;
          r_state <= ST_RWAIT;
        end
        // Capture read data RD_LAT cycles after the strobe and present its first byte
        ST_RWAIT: if (w_load) begin
          r_tx_data  <= w_byte_nxt;
          r_tx_valid <= 1'b1;
          r_state    <= ST_RSEND;
        end else begin
          r_lat <= r_lat + 2'd1;
        end
        ST_RSEND: if (tx_ready) begin
          if (!w_last) begin
            r_tx_data <= w_byte_nxt;
          end else begin
            r_tx_valid <= 1'b0;
            r_addr     <= r_addr + ADDR_W'(1);
            r_words    <= r_words - 9'd1;
            if (r_words == 9'd1) begin
              r_busy  <= 1'b0;
              r_state <= ST_IDLE;
            end else begin
              r_rden  <= 1'b1;
              r_state <= ST_RISSUE;
            end
          end
        end
        ST_ACK: if (tx_ready) begin
          r_tx_valid <= 1'b0;
          r_busy     <= 1'b0;
          r_state    <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
`ifdef UART_MEM_TIMEOUT_EN
      // Gap counter for the receive phases; expiry overrides the state update above
      r_timeout <= 1'b0;
      if (r_state inside {ST_ADDR, ST_CNT, ST_WDATA}) begin
        if (rx_valid) begin
          r_tcnt <= '0;
        end else if (r_tcnt == TW'(TIMEOUT_CYC - 1)) begin
          r_tcnt    <= '0;
          r_timeout <= 1'b1;
          r_busy    <= 1'b0;
          r_state   <= ST_IDLE;
        end else begin
          r_tcnt <= r_tcnt + TW'(1);
        end
      end else begin
        r_tcnt <= '0;
      end
`endif
    end
  end

  assign tx_data   = r_tx_data;
  assign tx_valid  = r_tx_valid;
  assign mem_addr  = r_addr;
  assign mem_wdata = r_wdata;
  assign mem_wren  = r_wren;
  assign mem_rden  = r_rden;
  assign busy      = r_busy;

endmodule

// File: doc/uart_mem_bridge.md
# uart_mem_bridge

Packet-level bridge between a UART byte stream and a single-port synchronous RAM. It replaces host-driven pin toggling of address, data, clock and enables with framed burst read and write commands. Addresses auto-increment within a burst, and address and data widths are parameters. It sits between the uart_recv/uart_send byte interfaces and the RAM port, in the sys_clk domain.

## Interface
- ADDR_W, 10: RAM address width; address field is AB=ceil(ADDR_W/8) bytes.
- DATA_W, 16: RAM word width; word is DB=ceil(DATA_W/8) bytes, MSB first.
- RD_LAT, 1: cycles from mem_rden pulse to valid mem_rdata (1..3).
- TIMEOUT_CYC, 500000: inter-byte gap limit (used only with the timeout feature).
- sys_clk  in  1  system clock, 50 MHz. Single clock; all logic is in this domain.
- sys_rst_n  in  1  reset, asynchronous, active-low.
- rx_data  in  8  received byte.
- rx_valid  in  1  one-cycle strobe, rx_data valid. No backpressure.
- tx_data  out  8  byte to transmit.
- tx_valid  out  1  tx_data valid; held until accepted.
- tx_ready  in  1  transmitter accepts a byte when tx_valid && tx_ready.
- mem_addr  out  ADDR_W  RAM address.
- mem_wdata  out  DATA_W  RAM write data.
- mem_wren  out  1  one-cycle write strobe.
- mem_rden  out  1  one-cycle read strobe.
- mem_rdata  in  DATA_W  RAM read data.
- busy  out  1  high whenever the state is not IDLE.
- timeout  out  1  one-cycle pulse when a frame is aborted (feature-dependent).

## Operation
- Frame format: CMD, AB address bytes (MSB first; bits above ADDR_W ignored), then COUNT byte (words = COUNT, 0 means 256).
- CMD 0x57 'W' (write): followed by COUNT×DB data bytes. After the last word is written, the bridge sends ACK byte 0x4B 'K'.
- CMD 0x52 'R' (read): the bridge returns COUNT×DB bytes, MSB first, with no ACK.
- Any other CMD byte in IDLE is discarded; the state stays IDLE.
- States:
  - IDLE → ADDR on valid CMD.
  - ADDR → CNT after AB bytes.
  - CNT → WDATA (write) or RISSUE (read).
  - WDATA → WSTROBE after DB bytes.
  - WSTROBE → WDATA, or ACK if the last word.
  - RISSUE → RWAIT → RSEND.
  - RSEND → RISSUE, or IDLE after the last byte of the last word is accepted.
  - ACK → IDLE when the ACK byte is accepted.
- Address increments by 1 after each word and wraps modulo 2^ADDR_W.
- Word counter is 9 bits wide.
- Partial bytes when DATA_W is not a multiple of 8: the excess high bits of the first byte are dropped on write and returned as zero on read.
- rx_valid outside IDLE/ADDR/CNT/WDATA (reading, sending, ACK) is ignored and the byte is dropped.
- Async reset mid-frame: immediate return to IDLE, tx_valid drops, and the partial burst is abandoned. Already-written words remain in RAM.

## Timing
- Reset values: tx_data=0, tx_valid=0, mem_addr=0, mem_wdata=0, mem_wren=0, mem_rden=0, busy=0, timeout=0.
- mem_wren is asserted the cycle after the rx_valid of a word's last byte. mem_addr and mem_wdata are stable during that cycle.
- Read: mem_rden pulses in RISSUE. mem_rdata is captured exactly RD_LAT cycles later, and tx_valid rises the following cycle.
- tx_data and tx_valid stay stable until tx_ready. The next byte is presented the cycle after acceptance.
- Next read is issued only after the previous word's last byte is accepted; there is no read-ahead.
- mem_wren and mem_rden are never high together.

## Configuration
- UART_MEM_TIMEOUT_EN defined:
  - In ADDR/CNT/WDATA, a counter resets on every rx_valid.
  - Reaching TIMEOUT_CYC aborts to IDLE and pulses timeout for one cycle. No ACK is sent; words already written are kept.
- Not defined: no counter, timeout is tied to 0, and a stalled frame waits indefinitely.

## Structure
- Package uart_mem_pkg:
  - CMD_WR=8'h57, CMD_RD=8'h52, ACK_BYTE=8'h4B.
  - State enum.
  - Function for the ceil-bytes calculation.
- Sub-module uart_mem_word_serdes: shifts bytes into a DATA_W word, and a loaded word out byte-wise with a byte index counter. One instance serves both directions.

## Test plan
Defaults ADDR_W=10, DATA_W=16, RD_LAT=1.
- Write: rx 57 01 23 02 AA BB CC DD → mem_wren at 0x123/AABB, then 0x124/CCDD; tx 4B.
- Read back: rx 52 01 23 02 → tx AA BB CC DD; exactly two mem_rden pulses at 0x123, 0x124.
- Wrap: rx 57 FF FF 02 11 22 33 44 → writes 0x3FF=1122, 0x000=3344.
- Garbage and backpressure:
  - rx 00 7F, then a valid read frame → garbage ignored, read data correct.
  - tx_ready held low 20 cycles → tx_data held stable, no extra mem_rden.
- COUNT=0 read → 512 bytes returned; the address crosses the 0x3FF→0x000 boundary correctly.
- With UART_MEM_TIMEOUT_EN, TIMEOUT_CYC=100:
  - rx 57 01, then idle 101 cycles → timeout pulse, busy=0.
  - A following read frame completes normally.
